// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: FSM state encoding and the buffered store entry.
package store_buffer_pkg;

  localparam int SB_ADDR_W = 30;
  localparam int SB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } sb_state_t;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] adr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store queue: entry storage, head/tail pointers, occupancy count.
// With STORE_BUFFER_FORWARD_EN the entries, valid bits and head pointer are exposed for forwarding.
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  sb_entry_t        push_entry,
  input  logic             pop,
  output sb_entry_t        head_entry,
  output logic [CNT_W-1:0] count
`ifdef STORE_BUFFER_FORWARD_EN
  ,
  output logic [PTR_W-1:0] head,
  output logic [DEPTH-1:0] valid,
  output sb_entry_t        entries [DEPTH]
`endif
);

  sb_entry_t        entry_reg [DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;

  // Entry payload needs no reset; validity is tracked by count (and valid bits when forwarding).
  always_ff @(posedge clk) begin
    if (push) begin
      entry_reg[tail_reg] <= push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_entry = entry_reg[head_reg];
  assign count      = count_reg;

`ifdef STORE_BUFFER_FORWARD_EN
  logic [DEPTH-1:0] valid_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pop && head_reg == PTR_W'(i))  valid_reg[i] <= 1'b0;
        if (push && tail_reg == PTR_W'(i)) valid_reg[i] <= 1'b1;
      end
    end
  end

  assign head  = head_reg;
  assign valid = valid_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_expose
    assign entries[gi] = entry_reg[gi];
  end
`endif

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and a handshaked memory.
// Define STORE_BUFFER_FORWARD_EN to forward loads from buffered stores (youngest match wins).
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [31:0]       cpu_adr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic [DATA_W-1:0] cpu_rd,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  input  logic              mem_ack,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_state_t         state_reg, state_next;
  logic              mem_req_reg, mem_we_reg;
  logic [ADDR_W-1:0] mem_adr_reg;
  logic [DATA_W-1:0] mem_wd_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic [CNT_W-1:0]  count;
  sb_entry_t         head_entry;
  logic              full, push, pop, load_req, hit;
  logic [DATA_W-1:0] hit_data;
  logic [29:0]       word_adr;
  logic              unused_adr_bits;

  assign word_adr        = cpu_adr[31:2];
  assign unused_adr_bits = ^cpu_adr[1:0];
  assign load_req        = cpu_re && !cpu_we;
  assign full            = (count == CNT_W'(DEPTH));
  assign push            = cpu_we && !full;
  assign pop             = (state_reg == WRITE) && mem_ack;
  assign empty           = (count == '0);

`ifdef STORE_BUFFER_FORWARD_EN
  logic [PTR_W-1:0] head;
  logic [DEPTH-1:0] valid;
  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] match;

  store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry ('{adr: word_adr, data: cpu_wd}),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count),
    .head       (head),
    .valid      (valid),
    .entries    (entries)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi] = valid[gi] && (entries[gi].adr == word_adr);
  end

  // Walk from oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[head + PTR_W'(i)]) begin
        hit      = 1'b1;
        hit_data = entries[head + PTR_W'(i)].data;
      end
    end
  end
`else
  store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry ('{adr: word_adr, data: cpu_wd}),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count)
  );

  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Buffered stores always drain before a load read, which keeps memory ordering intact.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (count != '0)           state_next = WRITE;
        else if (load_req && !hit) state_next = READ;
      end
      WRITE:   if (mem_ack) state_next = IDLE;
      READ:    if (mem_ack) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall  = 1'b0;
    cpu_rd = '0;
    if (cpu_we) begin
      stall = full;
    end else if (cpu_re) begin
      if (hit)                    cpu_rd = hit_data;
      else if (state_reg == RESP) cpu_rd = rdata_reg;
      else                        stall  = 1'b1;
    end
  end

  // Memory-side request registers; all fields return to zero when no request is outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_reg <= 1'b0;
      mem_we_reg  <= 1'b0;
      mem_adr_reg <= '0;
      mem_wd_reg  <= '0;
      rdata_reg   <= '0;
    end else begin
      if (state_reg == IDLE && state_next == WRITE) begin
        mem_req_reg <= 1'b1;
        mem_we_reg  <= 1'b1;
        mem_adr_reg <= head_entry.adr;
        mem_wd_reg  <= head_entry.data;
      end else if (state_reg == IDLE && state_next == READ) begin
        mem_req_reg <= 1'b1;
        mem_we_reg  <= 1'b0;
        mem_adr_reg <= word_adr;
        mem_wd_reg  <= '0;
      end else if ((state_reg == WRITE || state_reg == READ) && mem_ack) begin
        mem_req_reg <= 1'b0;
        mem_we_reg  <= 1'b0;
        mem_adr_reg <= '0;
        mem_wd_reg  <= '0;
        if (state_reg == READ) rdata_reg <= mem_rd;
      end
    end
  end

  assign mem_req = mem_req_reg;
  assign mem_we  = mem_we_reg;
  assign mem_adr = mem_adr_reg;
  assign mem_wd  = mem_wd_reg;

endmodule
